// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if
// Groups the read-side FIFO signals: the synchronised write pointer, the
// memory read port, the output handshake, and the status/error lines.
//   rsync_ptr2   : gray write pointer, already synchronised into the read clock
//   mem_rdata    : memory read data (combinational read of raddr)
//   raddr        : memory read address
//   rptr         : registered gray read pointer, sent to the write domain
//   dout         : output-stage data word
//   dout_valid   : dout holds a word
//   dout_ready   : consumer accepts dout this cycle
//   empty        : memory holds no unread word (output stage excluded)
//   almost_empty : rlevel at or below the threshold
//   rlevel       : unread words in memory
//   ptr_err      : sticky pointer-corruption flag
//   clr_err      : synchronous clear of ptr_err
// The master modport is the controller's view; slave is the environment's view.
interface fifo_rd_ctrl_if #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       rsync_ptr2;
   logic [DATA_W-1:0] mem_rdata;
   logic [AW-1:0]     raddr;
   logic [AW:0]       rptr;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              empty;
   logic              almost_empty;
   logic [AW:0]       rlevel;
   logic              ptr_err;
   logic              clr_err;

   modport master (
      input  rsync_ptr2, mem_rdata, dout_ready, clr_err,
      output raddr, rptr, dout, dout_valid, empty, almost_empty, rlevel, ptr_err
   );

   modport slave (
      output rsync_ptr2, mem_rdata, dout_ready, clr_err,
      input  raddr, rptr, dout, dout_valid, empty, almost_empty, rlevel, ptr_err
   );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
// Read-domain controller for the async FIFO. Owns the binary/gray read
// pointer, derives empty/almost-empty/level from the synchronised gray write
// pointer, and presents data through a registered first-word-fall-through
// output stage with a valid/ready handshake.
//   r_clk : read-domain clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_rd_ctrl_if master modport (pointers, memory port,
//           output handshake, status and error signals)
module fifo_rd_ctrl #(
   parameter int DEPTH         = 8,
   parameter int DATA_W        = 8,
   parameter int AEMPTY_THRESH = 2
) (
   input logic            r_clk,
   input logic            rst_n,
   fifo_rd_ctrl_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AEMPTY_W = (AW+1)'(AEMPTY_THRESH);

   typedef enum logic {
      EMPTY_S = 1'b0,
      FULL_S  = 1'b1
   } state_t;

   state_t            state;
   logic [AW:0]       rbin;
   logic [AW:0]       rbin_inc;
   logic [AW:0]       rptr_q;
   logic [AW:0]       wbin_s;
   logic [AW:0]       level;
   logic [DATA_W-1:0] dout_q;
   logic              dout_valid_q;
   logic              ptr_err_q;
   logic              empty_c;
   logic              level_bad;
   logic              pop;

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   always_comb begin
      wbin_s = '0;
      for (int i = 0; i <= AW; i++) begin
         wbin_s[i] = ^(bus.rsync_ptr2 >> i);
      end
   end

   // Status is combinational on registered pointers. The level subtraction is
   // modulo 2^(AW+1), so it stays correct when either pointer wraps.
   assign empty_c   = (bus.rsync_ptr2 == rptr_q);
   assign level     = wbin_s - rbin;
   assign level_bad = (level > DEPTH_W);
   assign rbin_inc  = rbin + 1'b1;

   // A corrupt pointer blocks popping so a bogus level can never drain memory.
   assign pop = !empty_c && !level_bad && ((state == EMPTY_S) || bus.dout_ready);

   // Output stage, pointer and error flag. rptr is recomputed from the
   // incremented binary pointer so it is always the gray image of rbin.
   always_ff @(posedge r_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= EMPTY_S;
         dout_valid_q <= 1'b0;
         dout_q       <= '0;
         rbin         <= '0;
         rptr_q       <= '0;
         ptr_err_q    <= 1'b0;
      end else begin
         if (pop) begin
            state        <= FULL_S;
            dout_valid_q <= 1'b1;
            dout_q       <= bus.mem_rdata;
            rbin         <= rbin_inc;
            rptr_q       <= rbin_inc ^ (rbin_inc >> 1);
         end else if ((state == FULL_S) && bus.dout_ready) begin
            state        <= EMPTY_S;
            dout_valid_q <= 1'b0;
         end

         // Setting wins over clearing while the corruption persists.
         if (level_bad) begin
            ptr_err_q <= 1'b1;
         end else if (bus.clr_err) begin
            ptr_err_q <= 1'b0;
         end
      end
   end

   assign bus.raddr        = rbin[AW-1:0];
   assign bus.rptr         = rptr_q;
   assign bus.dout         = dout_q;
   assign bus.dout_valid   = dout_valid_q;
   assign bus.empty        = empty_c;
   assign bus.rlevel       = level;
   assign bus.almost_empty = (level <= AEMPTY_W);
   assign bus.ptr_err      = ptr_err_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl
// Self-checking bench for fifo_rd_ctrl with DEPTH=8, DATA_W=8, AEMPTY_THRESH=2.
// A small behavioural memory answers raddr combinationally.
module tb_fifo_rd_ctrl;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 8;

   logic r_clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] mem [0:7];
   int n_checks = 0;
   int n_pass   = 0;

   always #5 r_clk = ~r_clk;

   fifo_rd_ctrl_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   assign bus.mem_rdata = mem[bus.raddr];

   fifo_rd_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AEMPTY_THRESH(2)) dut (
      .r_clk (r_clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   typedef struct {
      logic [3:0] rsync;
      logic       ready;
      logic       clr;
      logic [7:0] e_dout;
      logic       e_valid;
      logic [3:0] e_rptr;
      logic       e_empty;
      logic [3:0] e_level;
      logic       e_ae;
      logic       e_err;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [3:0] gray(input int b);
      logic [3:0] x;
      x = 4'(b);
      return x ^ (x >> 1);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic [3:0] rsync, input logic ready, input logic clr);
      bus.rsync_ptr2 = rsync;
      bus.dout_ready = ready;
      bus.clr_err    = clr;
      @(posedge r_clk);
      #1;
   endtask

   task automatic doReset();
      bus.rsync_ptr2 = '0;
      bus.dout_ready = 1'b0;
      bus.clr_err    = 1'b0;
      rst_n = 1'b0;
      @(negedge r_clk);
      @(negedge r_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      int w;
      logic [3:0] prev_rptr;

      // Eight-word burst after reset with mem[i]=i and the consumer always ready.
      vecs[0] = '{4'b1100, 1'b1, 1'b0, 8'd0, 1'b1, 4'b0001, 1'b0, 4'd7, 1'b0, 1'b0};
      vecs[1] = '{4'b1100, 1'b1, 1'b0, 8'd1, 1'b1, 4'b0011, 1'b0, 4'd6, 1'b0, 1'b0};
      vecs[2] = '{4'b1100, 1'b1, 1'b0, 8'd2, 1'b1, 4'b0010, 1'b0, 4'd5, 1'b0, 1'b0};
      vecs[3] = '{4'b1100, 1'b1, 1'b0, 8'd3, 1'b1, 4'b0110, 1'b0, 4'd4, 1'b0, 1'b0};
      vecs[4] = '{4'b1100, 1'b1, 1'b0, 8'd4, 1'b1, 4'b0111, 1'b0, 4'd3, 1'b0, 1'b0};
      vecs[5] = '{4'b1100, 1'b1, 1'b0, 8'd5, 1'b1, 4'b0101, 1'b0, 4'd2, 1'b1, 1'b0};
      vecs[6] = '{4'b1100, 1'b1, 1'b0, 8'd6, 1'b1, 4'b0100, 1'b0, 4'd1, 1'b1, 1'b0};
      vecs[7] = '{4'b1100, 1'b1, 1'b0, 8'd7, 1'b1, 4'b1100, 1'b1, 4'd0, 1'b1, 1'b0};
      vecs[8] = '{4'b1100, 1'b1, 1'b0, 8'd7, 1'b0, 4'b1100, 1'b1, 4'd0, 1'b1, 1'b0};

      for (int i = 0; i < 8; i++) mem[i] = 8'h00;

      // Reset state.
      doReset();
      #1;
      checkOutput("rst_valid", 32'(bus.dout_valid), 32'd0);
      checkOutput("rst_empty", 32'(bus.empty), 32'd1);
      checkOutput("rst_level", 32'(bus.rlevel), 32'd0);
      checkOutput("rst_ae", 32'(bus.almost_empty), 32'd1);
      checkOutput("rst_rptr", 32'(bus.rptr), 32'd0);
      checkOutput("rst_dout", 32'(bus.dout), 32'd0);
      checkOutput("rst_err", 32'(bus.ptr_err), 32'd0);

      // Single word, then backpressure for five cycles.
      mem[0] = 8'hA5;
      applyStimulus(4'b0001, 1'b0, 1'b0);
      checkOutput("one_dout", 32'(bus.dout), 32'hA5);
      checkOutput("one_valid", 32'(bus.dout_valid), 32'd1);
      checkOutput("one_rptr", 32'(bus.rptr), 32'b0001);
      checkOutput("one_empty", 32'(bus.empty), 32'd1);
      mem[0] = 8'h11;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0001, 1'b0, 1'b0);
         checkOutput("hold_dout", 32'(bus.dout), 32'hA5);
         checkOutput("hold_rptr", 32'(bus.rptr), 32'b0001);
         checkOutput("hold_valid", 32'(bus.dout_valid), 32'd1);
      end

      // Table-driven burst.
      doReset();
      for (int i = 0; i < 8; i++) mem[i] = 8'(i);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].rsync, vecs[i].ready, vecs[i].clr);
         checkOutput($sformatf("burst%0d_dout", i), 32'(bus.dout), 32'(vecs[i].e_dout));
         checkOutput($sformatf("burst%0d_valid", i), 32'(bus.dout_valid), 32'(vecs[i].e_valid));
         checkOutput($sformatf("burst%0d_rptr", i), 32'(bus.rptr), 32'(vecs[i].e_rptr));
         checkOutput($sformatf("burst%0d_empty", i), 32'(bus.empty), 32'(vecs[i].e_empty));
         checkOutput($sformatf("burst%0d_level", i), 32'(bus.rlevel), 32'(vecs[i].e_level));
         checkOutput($sformatf("burst%0d_ae", i), 32'(bus.almost_empty), 32'(vecs[i].e_ae));
         checkOutput($sformatf("burst%0d_err", i), 32'(bus.ptr_err), 32'(vecs[i].e_err));
      end

      // Twenty-word stream with the writer three ahead; pointers wrap at 16.
      doReset();
      k = 0;
      prev_rptr = 4'b0000;
      for (int step = 0; step < 20; step++) begin
         w = (k + 3 > 20) ? 20 : k + 3;
         for (int n = k; n < w; n++) mem[n % 8] = 8'(8'h40 + n);
         applyStimulus(gray(w % 16), 1'b1, 1'b0);
         checkOutput($sformatf("strm%0d_dout", step), 32'(bus.dout), 32'(8'h40 + k));
         checkOutput($sformatf("strm%0d_valid", step), 32'(bus.dout_valid), 32'd1);
         checkOutput($sformatf("strm%0d_rptr", step), 32'(bus.rptr), 32'(gray((k + 1) % 16)));
         checkOutput($sformatf("strm%0d_onebit", step), 32'($countones(bus.rptr ^ prev_rptr)), 32'd1);
         checkOutput($sformatf("strm%0d_empty", step), 32'(bus.empty), 32'(w == k + 1));
         prev_rptr = bus.rptr;
         k++;
      end

      // Corrupt write pointer: gray 1010 is binary 12.
      doReset();
      bus.rsync_ptr2 = 4'b1010;
      #1;
      checkOutput("err_level", 32'(bus.rlevel), 32'd12);
      applyStimulus(4'b1010, 1'b0, 1'b0);
      checkOutput("err_set", 32'(bus.ptr_err), 32'd1);
      checkOutput("err_nopop_valid", 32'(bus.dout_valid), 32'd0);
      checkOutput("err_nopop_rptr", 32'(bus.rptr), 32'd0);
      applyStimulus(4'b1010, 1'b1, 1'b0);
      checkOutput("err_nopop2_valid", 32'(bus.dout_valid), 32'd0);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("err_sticky", 32'(bus.ptr_err), 32'd1);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("err_cleared", 32'(bus.ptr_err), 32'd0);
      applyStimulus(4'b1010, 1'b0, 1'b0);
      checkOutput("err_reset", 32'(bus.ptr_err), 32'd1);
      applyStimulus(4'b1010, 1'b0, 1'b1);
      checkOutput("err_set_wins", 32'(bus.ptr_err), 32'd1);

      // Asynchronous reset in the middle of a burst.
      doReset();
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h80 + i);
      for (int i = 0; i < 3; i++) applyStimulus(4'b1100, 1'b1, 1'b0);
      checkOutput("mid_dout", 32'(bus.dout), 32'h82);
      checkOutput("mid_valid", 32'(bus.dout_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_valid", 32'(bus.dout_valid), 32'd0);
      checkOutput("arst_rptr", 32'(bus.rptr), 32'd0);
      checkOutput("arst_dout", 32'(bus.dout), 32'd0);
      bus.rsync_ptr2 = 4'b0000;
      @(negedge r_clk);
      rst_n = 1'b1;
      mem[0] = 8'h5A;
      applyStimulus(4'b0001, 1'b1, 1'b0);
      checkOutput("resume_dout", 32'(bus.dout), 32'h5A);
      checkOutput("resume_valid", 32'(bus.dout_valid), 32'd1);
      checkOutput("resume_rptr", 32'(bus.rptr), 32'b0001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
